mem_arbiter: RTL and testbench

Two-port arbiter and sequencer for the single-port 1024-word data/instruction memory of the multicycle MIPS datapath. Shares the memory between the CPU control path (port A) and the program loader/debug port (port B) with round-robin fairness. Each access is latched, driven onto the memory for exactly one cycle, and acknowledged with a one-cycle pulse. Read data is returned through a registered per-port buffer.

---
 rtl/mem_arbiter.sv | 145 ++++++++++++++
 tb/tb_mem_arbiter.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter/sequencer in front of the single-port MIPS data/instruction memory.
// Each granted access spends one cycle on the memory and one cycle acknowledging the requester.
module mem_arbiter #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned ADDR_BITS = 10
) (
  input  logic              clk,
  input  logic              reset,

  input  logic              a_req,
  input  logic              a_we,
  input  logic [31:0]       a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_ack,
  output logic              a_err,
  output logic [DATA_W-1:0] a_rdata,

  input  logic              b_req,
  input  logic              b_we,
  input  logic [31:0]       b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_ack,
  output logic              b_err,
  output logic [DATA_W-1:0] b_rdata,

  output logic [31:0]       mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int unsigned AW = 32;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] ACK    = 2'd2;

  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

  logic [1:0]           state;
  logic [1:0]           state_nxt;

  logic                 grant_vld;
  logic                 grant_port;
  logic                 last;

  logic                 lat_port;
  logic                 lat_we;
  logic                 lat_in_range;
  logic [ADDR_BITS-1:0] lat_addr;
  logic [DATA_W-1:0]    lat_wdata;

  logic                 a_in_range;
  logic                 b_in_range;
  logic                 rd_capture;
  logic [DATA_W-1:0]    rd_value;

  assign a_in_range = (a_addr[AW-1:ADDR_BITS] == '0);
  assign b_in_range = (b_addr[AW-1:ADDR_BITS] == '0);

  // On a tie the port that was not granted last wins
  always_comb begin
    grant_vld  = a_req | b_req;
    grant_port = PORT_A;
    if (a_req && b_req) begin
      grant_port = ~last;
    end else if (b_req) begin
      grant_port = PORT_B;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant_vld) state_nxt = ACCESS;
      ACCESS:  state_nxt = ACK;
      ACK:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Latch the granted request; the other port is ignored until the next IDLE
  always_ff @(posedge clk) begin
    if (reset) begin
      last         <= PORT_B;
      lat_port     <= PORT_A;
      lat_we       <= 1'b0;
      lat_in_range <= 1'b0;
      lat_addr     <= '0;
      lat_wdata    <= '0;
    end else if (state == IDLE && grant_vld) begin
      last     <= grant_port;
      lat_port <= grant_port;
      if (grant_port == PORT_B) begin
        lat_we       <= b_we;
        lat_in_range <= b_in_range;
        lat_addr     <= b_addr[ADDR_BITS-1:0];
        lat_wdata    <= b_wdata;
      end else begin
        lat_we       <= a_we;
        lat_in_range <= a_in_range;
        lat_addr     <= a_addr[ADDR_BITS-1:0];
        lat_wdata    <= a_wdata;
      end
    end
  end

  // Out-of-range reads return zero without touching the memory
  assign rd_capture = (state == ACCESS) && !lat_we;
  assign rd_value   = lat_in_range ? mem_rdata : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      a_rdata <= '0;
      b_rdata <= '0;
    end else if (rd_capture) begin
      if (lat_port == PORT_B) begin
        b_rdata <= rd_value;
      end else begin
        a_rdata <= rd_value;
      end
    end
  end

  assign mem_addr  = AW'(lat_addr);
  assign mem_wdata = lat_wdata;
  assign mem_we    = (state == ACCESS) && lat_in_range &&  lat_we && !reset;
  assign mem_re    = (state == ACCESS) && lat_in_range && !lat_we && !reset;

  assign a_ack = (state == ACK) && (lat_port == PORT_A);
  assign b_ack = (state == ACK) && (lat_port == PORT_B);
  assign a_err = a_ack && !lat_in_range;
  assign b_err = b_ack && !lat_in_range;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: transaction-level arbitration model feeds expected acks and memory
// accesses into queues; a negedge monitor pops and compares whatever the DUT presents.
module tb_mem_arbiter;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned WORDS  = 1024;

  logic              clk = 1'b0;
  logic              reset;
  logic              a_req, a_we, b_req, b_we;
  logic [31:0]       a_addr, b_addr;
  logic [DATA_W-1:0] a_wdata, b_wdata;
  logic              a_ack, a_err, b_ack, b_err;
  logic [DATA_W-1:0] a_rdata, b_rdata;
  logic [31:0]       mem_addr;
  logic [DATA_W-1:0] mem_wdata, mem_rdata;
  logic              mem_we, mem_re;

  mem_arbiter #(.DATA_W(DATA_W), .ADDR_BITS(10)) dut (
    .clk(clk), .reset(reset),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_ack(a_ack), .a_err(a_err), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_ack(b_ack), .b_err(b_err), .b_rdata(b_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct { bit we; logic [31:0] addr; logic [31:0] wdata; } op_t;
  typedef struct { bit port; bit err; logic [31:0] ard; logic [31:0] brd; int cyc; } ack_t;
  typedef struct { bit we; logic [31:0] addr; logic [31:0] wdata; int cyc; } macc_t;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit mon_en = 1'b0;

  logic [31:0] tb_mem  [WORDS];
  logic [31:0] ref_mem [WORDS];
  logic [31:0] exp_rd  [2];
  bit          last_b;

  op_t   qa[$], qb[$];
  ack_t  ack_q[$];
  macc_t mem_q[$];

  // Memory: combinational read; an undriven bus is modelled by a marker pattern
  assign mem_rdata = mem_re ? tb_mem[mem_addr[9:0]] : 32'hBAD0_BAD0;
  always @(posedge clk) begin
    if (mem_we) tb_mem[mem_addr[9:0]] <= mem_wdata;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: one IDLE sample slot every 3 cycles, round-robin on ties
  function automatic void model_round(input int k);
    int s, ia, ib;
    bit port, inr;
    op_t o;
    s = k + 1; ia = 0; ib = 0;
    while (ia < qa.size() || ib < qb.size()) begin
      if (ia < qa.size() && ib < qb.size()) port = last_b ? 1'b0 : 1'b1;
      else port = (ia < qa.size()) ? 1'b0 : 1'b1;
      last_b = port;
      if (port) begin o = qb[ib]; ib++; end
      else      begin o = qa[ia]; ia++; end
      inr = (o.addr >= 32'(WORDS)) ? 1'b0 : 1'b1;
      if (inr) begin
        mem_q.push_back('{we: o.we, addr: {22'b0, o.addr[9:0]}, wdata: o.wdata, cyc: s});
        if (o.we) ref_mem[o.addr[9:0]] = o.wdata;
      end
      if (!o.we) exp_rd[port] = inr ? ref_mem[o.addr[9:0]] : 32'h0;
      ack_q.push_back('{port: port, err: !inr, ard: exp_rd[0], brd: exp_rd[1], cyc: s + 1});
      s += 3;
    end
  endfunction

  task automatic drive_a(input op_t o);
    a_req = 1'b1; a_we = o.we; a_addr = o.addr; a_wdata = o.wdata;
  endtask

  task automatic drive_b(input op_t o);
    b_req = 1'b1; b_we = o.we; b_addr = o.addr; b_wdata = o.wdata;
  endtask

  // Each port chains its next op (or drops req) at the edge that closes its ACK
  task automatic run_round();
    int na, nb, ia, ib;
    bit ga, gb, done;
    na = qa.size(); nb = qb.size();
    if (na + nb == 0) return;
    model_round(cyc);
    ia = 0; ib = 0;
    if (na > 0) drive_a(qa[0]);
    if (nb > 0) drive_b(qb[0]);
    done = 1'b0;
    for (int c = 0; c < 64 && !done; c++) begin
      @(negedge clk);
      ga = a_ack; gb = b_ack;
      @(posedge clk); #1;
      if (ga) begin ia++; if (ia < na) drive_a(qa[ia]); else a_req = 1'b0; end
      if (gb) begin ib++; if (ib < nb) drive_b(qb[ib]); else b_req = 1'b0; end
      done = (ia >= na) && (ib >= nb);
    end
    if (!done) begin
      check("round_timeout", 32'd0, 32'd1);
      a_req = 1'b0; b_req = 1'b0;
    end
    qa.delete(); qb.delete();
  endtask

  function automatic op_t mk(input bit we, input logic [31:0] addr, input logic [31:0] wdata);
    op_t o;
    o.we = we; o.addr = addr; o.wdata = wdata;
    return o;
  endfunction

  function automatic op_t rand_op();
    op_t o;
    int r;
    r = $urandom_range(0, 9);
    o.we = 1'($urandom_range(0, 1));
    o.wdata = $urandom;
    case (r)
      0:       o.addr = 32'h400 + 32'($urandom_range(0, 255));
      1:       o.addr = $urandom | 32'h8000_0000;
      2:       o.addr = 32'h3FF - 32'($urandom_range(0, 3));
      default: o.addr = 32'($urandom_range(0, 15));
    endcase
    return o;
  endfunction

  task automatic check_reset_outputs();
    check("rst_ack_err", {28'b0, a_ack, a_err, b_ack, b_err}, 32'h0);
    check("rst_a_rdata", a_rdata, 32'h0);
    check("rst_b_rdata", b_rdata, 32'h0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_mem_wdata", mem_wdata, 32'h0);
    check("rst_mem_we_re", {30'b0, mem_we, mem_re}, 32'h0);
  endtask

  task automatic model_reset();
    last_b = 1'b1;
    exp_rd[0] = 32'h0;
    exp_rd[1] = 32'h0;
  endtask

  // Monitor: compare every ack and every memory strobe against the queued expectations
  always @(negedge clk) begin
    ack_t  ea;
    macc_t em;
    if (mon_en) begin
      check("err_without_ack", {30'b0, a_err & ~a_ack, b_err & ~b_ack}, 32'h0);
      check("we_and_re", {31'b0, mem_we & mem_re}, 32'h0);
      if (a_ack || b_ack) begin
        if (ack_q.size() == 0) begin
          check("unexpected_ack", {30'b0, a_ack, b_ack}, 32'h0);
        end else begin
          ea = ack_q.pop_front();
          check("ack_port", {30'b0, a_ack, b_ack}, ea.port ? 32'h1 : 32'h2);
          check("ack_err", {31'b0, ea.port ? b_err : a_err}, {31'b0, ea.err});
          check("ack_cycle", 32'(cyc), 32'(ea.cyc));
          check("a_rdata", a_rdata, ea.ard);
          check("b_rdata", b_rdata, ea.brd);
        end
      end
      if (mem_we || mem_re) begin
        if (mem_q.size() == 0) begin
          check("unexpected_mem_access", {30'b0, mem_we, mem_re}, 32'h0);
        end else begin
          em = mem_q.pop_front();
          check("mem_we", {31'b0, mem_we}, {31'b0, em.we});
          check("mem_addr", mem_addr, em.addr);
          check("mem_wdata", mem_wdata, em.wdata);
          check("mem_cycle", 32'(cyc), 32'(em.cyc));
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < int'(WORDS); i++) begin
      tb_mem[i]  = 32'(i) * 32'h0101_0101 ^ 32'h5A5A_0000;
      ref_mem[i] = tb_mem[i];
    end
    tb_mem[5] = 32'hDEAD_BEEF; ref_mem[5] = 32'hDEAD_BEEF;
    tb_mem[7] = 32'h0000_0001; ref_mem[7] = 32'h0000_0001;

    reset = 1'b1;
    a_req = 1'b0; a_we = 1'b0; a_addr = 32'h0; a_wdata = 32'h0;
    b_req = 1'b0; b_we = 1'b0; b_addr = 32'h0; b_wdata = 32'h0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check_reset_outputs();
    mon_en = 1'b1;
    @(posedge clk); #1;

    // Tie from reset: A, B, A, B
    qa.push_back(mk(1'b0, 32'd5, 32'h0));
    qa.push_back(mk(1'b1, 32'd20, 32'hA5A5_0020));
    qb.push_back(mk(1'b0, 32'd7, 32'h0));
    qb.push_back(mk(1'b0, 32'd20, 32'h0));
    run_round();

    // Single A read, single B write, then read-back through A
    qa.push_back(mk(1'b0, 32'd5, 32'h0));
    run_round();
    qb.push_back(mk(1'b1, 32'd12, 32'h1234_5678));
    run_round();
    qa.push_back(mk(1'b0, 32'd12, 32'h0));
    run_round();

    // Range boundary: 0x400 read/write, then word 0 and 0x3FF
    qa.push_back(mk(1'b0, 32'h400, 32'h0));
    qa.push_back(mk(1'b1, 32'h400, 32'hFFFF_0000));
    qa.push_back(mk(1'b0, 32'h0, 32'h0));
    qb.push_back(mk(1'b1, 32'h3FF, 32'h0BAD_F00D));
    qb.push_back(mk(1'b0, 32'h3FF, 32'h0));
    run_round();

    // Reset during the ACCESS cycle of a B write to word 7
    drive_b(mk(1'b1, 32'd7, 32'hCAFE_F00D));
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    check("reset_blocks_write", {30'b0, mem_we, mem_re}, 32'h0);
    @(posedge clk); #1;
    reset = 1'b0; b_req = 1'b0;
    model_reset();
    @(negedge clk);
    check_reset_outputs();
    @(posedge clk); #1;
    qa.push_back(mk(1'b0, 32'd7, 32'h0));
    run_round();

    // Back-to-back A with changing address, B idle
    for (int i = 0; i < 6; i++) qa.push_back(mk(1'b0, 32'(i + 3), 32'h0));
    run_round();

    // Random rounds
    for (int r = 0; r < 80; r++) begin
      int na, nb;
      na = $urandom_range(0, 3);
      nb = $urandom_range(0, 3);
      for (int i = 0; i < na; i++) qa.push_back(rand_op());
      for (int i = 0; i < nb; i++) qb.push_back(rand_op());
      run_round();
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end

    // Final read sweep of the touched words
    for (int i = 0; i < 16; i++) qb.push_back(mk(1'b0, 32'(i), 32'h0));
    run_round();

    repeat (4) @(posedge clk);
    @(negedge clk);
    check("ack_queue_drained", 32'(ack_q.size()), 32'h0);
    check("mem_queue_drained", 32'(mem_q.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
